// File: rtl/float_div_16bit_if.sv
// Half-precision format package and divider handshake interface.
//   fpu_types_pkg      : binary16 field widths and the packed half_float_t payload.
//   float_div_16bit_if : start/operands from the requester (master),
//                        busy/done/quotient/flags from the divider (slave).
package fpu_types_pkg;
  localparam int unsigned HALF_FLOAT_W    = 16;
  localparam int unsigned HALF_EXPONENT_W = 5;
  localparam int unsigned HALF_FRACTION_W = 10;

  typedef struct packed {
    logic                       sign;
    logic [HALF_EXPONENT_W-1:0] exponent;
    logic [HALF_FRACTION_W-1:0] fraction;
  } half_float_t;
endpackage

interface float_div_16bit_if;
  import fpu_types_pkg::*;

  logic        start;
  half_float_t float1;
  half_float_t float2;
  logic        busy;
  logic        done;
  half_float_t quotient;
  logic        div_by_zero;
  logic        invalid;

  modport master (
    output start, float1, float2,
    input  busy, done, quotient, div_by_zero, invalid
  );

  modport slave (
    input  start, float1, float2,
    output busy, done, quotient, div_by_zero, invalid
  );
endinterface

// File: rtl/float_div_16bit.sv
// Iterative binary16 divider: radix-2 restoring mantissa division, 13 iterations,
// round-to-nearest-even, one-cycle done pulse.
// Ports:
//   CLK   : clock, rising edge
//   nRST  : synchronous active-low reset
//   bus   : float_div_16bit_if.slave (start, float1, float2 in;
//           busy, done, quotient, div_by_zero, invalid out, all registered)
// Configuration macro: FPU_DIV_SUBNORMAL_EN
//   defined   : subnormal operands are normalized, subnormal results produced
//   undefined : subnormal operands read as zero, results with e <= 0 flush to +0
module float_div_16bit
  import fpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  float_div_16bit_if.slave  bus
);

  localparam int unsigned MANT_W = HALF_FRACTION_W + 1;  // hidden bit + fraction
  localparam int unsigned REM_W  = MANT_W + 1;           // partial remainder
  localparam int unsigned QUO_W  = MANT_W + 2;           // quotient + guard + round
  localparam int unsigned EXP_W  = 7;                    // signed working exponent
  localparam int unsigned CNT_W  = 4;

  localparam logic [CNT_W-1:0]           LAST_ITER = CNT_W'(QUO_W - 1);
  localparam logic [EXP_W-1:0]           BIAS      = EXP_W'(15);
  localparam logic [HALF_EXPONENT_W-1:0] EXP_MAX   = '1;
  localparam logic [HALF_FLOAT_W-1:0]    QNAN      = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_DIVIDE,
    S_NORM,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;   // two's complement effective exponent
  } op_norm_t;

  // Restore the hidden bit; left-justify subnormals with exponent 1-lz.
  function automatic op_norm_t normalize(input half_float_t f);
    op_norm_t res;
`ifdef FPU_DIV_SUBNORMAL_EN
    logic [3:0] lz;
`endif
    res.mant = {1'b1, f.fraction};
    res.exp  = EXP_W'(f.exponent);
`ifdef FPU_DIV_SUBNORMAL_EN
    if (f.exponent == '0) begin
      lz = '0;
      for (int i = 0; i < int'(HALF_FRACTION_W); i++) begin
        if (f.fraction[i]) lz = 4'(int'(HALF_FRACTION_W) - i);
      end
      res.mant = MANT_W'({1'b0, f.fraction} << lz);
      res.exp  = EXP_W'(1) - EXP_W'(lz);
    end
`endif
    return res;
  endfunction

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  half_float_t               r_a;
  half_float_t               r_b;
  logic                      r_sign;
  logic signed [EXP_W-1:0]   r_exp;
  logic [REM_W-1:0]          r_rem;
  logic [MANT_W-1:0]         r_m2;
  logic [QUO_W-1:0]          r_quo;
  half_float_t               r_res;
  logic                      r_res_dz;
  logic                      r_res_inv;
  logic                      r_busy;
  logic                      r_done;
  half_float_t               r_quotient;
  logic                      r_div_by_zero;
  logic                      r_invalid;

  // Operand classification.
  logic w_a_nan, w_a_inf, w_a_zero;
  logic w_b_nan, w_b_inf, w_b_zero;
  logic w_sign;

  always_comb begin
    w_sign  = r_a.sign ^ r_b.sign;
    w_a_nan = (r_a.exponent == EXP_MAX) && (r_a.fraction != '0);
    w_a_inf = (r_a.exponent == EXP_MAX) && (r_a.fraction == '0);
    w_b_nan = (r_b.exponent == EXP_MAX) && (r_b.fraction != '0);
    w_b_inf = (r_b.exponent == EXP_MAX) && (r_b.fraction == '0);
`ifdef FPU_DIV_SUBNORMAL_EN
    w_a_zero = (r_a.exponent == '0) && (r_a.fraction == '0);
    w_b_zero = (r_b.exponent == '0) && (r_b.fraction == '0);
`else
    w_a_zero = (r_a.exponent == '0);
    w_b_zero = (r_b.exponent == '0);
`endif
  end

  // Special-operand result, checked in priority order.
  logic        w_special;
  half_float_t w_spec_res;
  logic        w_spec_dz;
  logic        w_spec_inv;

  always_comb begin
    w_special  = 1'b1;
    w_spec_res = '0;
    w_spec_dz  = 1'b0;
    w_spec_inv = 1'b0;
    if (w_a_nan || w_b_nan) begin
      w_spec_res = QNAN;
      w_spec_inv = 1'b1;
    end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_res = QNAN;
      w_spec_inv = 1'b1;
    end else if (w_b_zero && !w_a_inf) begin
      w_spec_res.sign     = w_sign;
      w_spec_res.exponent = EXP_MAX;
      w_spec_dz           = 1'b1;
    end else if (w_a_inf) begin
      w_spec_res.sign     = w_sign;
      w_spec_res.exponent = EXP_MAX;
    end else if (w_a_zero || w_b_inf) begin
      w_spec_res = '0;
    end else begin
      w_special = 1'b0;
    end
  end

  // Normal-path setup: pre-shift the dividend so the quotient lands in [1,2).
  op_norm_t          w_na;
  op_norm_t          w_nb;
  logic              w_lt;
  logic [EXP_W-1:0]  w_e_prep;
  logic [REM_W-1:0]  w_rem_init;

  always_comb begin
    w_na       = normalize(r_a);
    w_nb       = normalize(r_b);
    w_lt       = (w_na.mant < w_nb.mant);
    w_e_prep   = w_na.exp - w_nb.exp + BIAS - EXP_W'(w_lt);
    w_rem_init = w_lt ? {w_na.mant, 1'b0} : {1'b0, w_na.mant};
  end

  // One restoring-division step.
  logic [REM_W:0]   w_diff;
  logic             w_ge;
  logic [REM_W-1:0] w_rem_next;

  always_comb begin
    w_diff     = {1'b0, r_rem} - {2'b0, r_m2};
    w_ge       = ~w_diff[REM_W];
    w_rem_next = w_ge ? REM_W'({w_diff[REM_W-1:0], 1'b0}) : REM_W'({r_rem, 1'b0});
  end

  // Denormalize, round to nearest even, and pack the final result.
  logic                    w_sub;
  logic                    w_flush;
  logic [QUO_W-1:0]        w_shq;
  logic                    w_lost;
  logic                    w_sticky;
  logic                    w_inc;
  logic [REM_W-1:0]        w_sum;
  logic signed [EXP_W-1:0] w_e_fin;
  half_float_t             w_norm_res;
`ifdef FPU_DIV_SUBNORMAL_EN
  logic [EXP_W-1:0]        w_shift;
`endif

  always_comb begin
    w_sub   = (r_exp <= 7'sd0);
    w_flush = 1'b0;
    w_shq   = r_quo;
    w_lost  = 1'b0;
`ifdef FPU_DIV_SUBNORMAL_EN
    w_shift = EXP_W'(7'sd1 - r_exp);
    if (w_sub) begin
      if (w_shift > EXP_W'(QUO_W - 1)) begin
        w_flush = 1'b1;
      end else begin
        w_shq  = r_quo >> w_shift[3:0];
        w_lost = |(r_quo & ~({QUO_W{1'b1}} << w_shift[3:0]));
      end
    end
`else
    w_flush = w_sub;
`endif
    w_sticky = (r_rem != '0) || w_lost;
    w_inc    = w_shq[1] & (w_shq[0] | w_sticky | w_shq[2]);
    w_sum    = {1'b0, w_shq[QUO_W-1:2]} + REM_W'(w_inc);
    w_e_fin  = r_exp + $signed(EXP_W'(w_sum[REM_W-1]));

    w_norm_res = '0;
    if (w_flush) begin
      w_norm_res = '0;
    end else if (w_sub) begin
      // Carry into bit 10 turns a subnormal into the smallest normal naturally.
      if (w_sum[MANT_W-1:0] != '0)
        w_norm_res = {w_sign_r(r_sign), 4'b0, w_sum[MANT_W-1:0]};
    end else if (w_e_fin >= 7'sd31) begin
      w_norm_res.sign     = r_sign;
      w_norm_res.exponent = EXP_MAX;
    end else begin
      w_norm_res.sign     = r_sign;
      w_norm_res.exponent = w_e_fin[HALF_EXPONENT_W-1:0];
      w_norm_res.fraction = w_sum[REM_W-1] ? w_sum[MANT_W-1:1] : w_sum[HALF_FRACTION_W-1:0];
    end
  end

  function automatic logic w_sign_r(input logic s);
    return s;
  endfunction

  // Control FSM and all registered state.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_sign        <= 1'b0;
      r_exp         <= '0;
      r_rem         <= '0;
      r_m2          <= '0;
      r_quo         <= '0;
      r_res         <= '0;
      r_res_dz      <= 1'b0;
      r_res_inv     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_div_by_zero <= 1'b0;
      r_invalid     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a           <= bus.float1;
            r_b           <= bus.float2;
            r_busy        <= 1'b1;
            r_div_by_zero <= 1'b0;
            r_invalid     <= 1'b0;
            r_state       <= S_PREP;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_PREP: begin
          r_sign <= w_sign;
          if (w_special) begin
            r_res     <= w_spec_res;
            r_res_dz  <= w_spec_dz;
            r_res_inv <= w_spec_inv;
            r_state   <= S_DONE;
          end else begin
            r_res_dz  <= 1'b0;
            r_res_inv <= 1'b0;
            r_exp     <= $signed(w_e_prep);
            r_rem     <= w_rem_init;
            r_m2      <= w_nb.mant;
            r_quo     <= '0;
            r_cnt     <= '0;
            r_state   <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[QUO_W-2:0], w_ge};
          if (r_cnt == LAST_ITER) begin
            r_cnt   <= '0;
            r_state <= S_NORM;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_NORM: begin
          r_res   <= w_norm_res;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done        <= 1'b1;
          r_quotient    <= r_res;
          r_div_by_zero <= r_res_dz;
          r_invalid     <= r_res_inv;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quotient;
  assign bus.div_by_zero = r_div_by_zero;
  assign bus.invalid     = r_invalid;

endmodule
